data_sync: RTL and testbench



---
 rtl/data_sync_pkg.sv | 17 +
 rtl/data_sync_bit_sync.sv | 28 ++
 rtl/data_sync.sv | 78 +++++++
 tb/tb_data_sync.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared constants for the bus-enable clock-domain-crossing receiver.
// Default synchronizer depth and bus width are exported here so that
// system-level code can size its crossings consistently.
package data_sync_pkg;

    // Default number of flops in the bus_enable synchronizer (legal >= 2).
    localparam int DS_NUM_STAGES = 2;

    // Default width of the crossing data bus (legal >= 1).
    localparam int DS_BUS_WIDTH  = 8;

    // Edges from bus_enable first being sampled to Sync_bus/enable_pulse update.
    function automatic int ds_capture_latency(input int num_stages);
        return num_stages;
    endfunction

endpackage : data_sync_pkg

// File: rtl/data_sync_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// The chain is a pure shift register: no logic is placed between stages so
// each flop has a full clock period to resolve metastability.
module data_sync_bit_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES = DS_NUM_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [NUM_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the chain; stage 0 samples the raw input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[NUM_STAGES-1];

endmodule : data_sync_bit_sync

// File: rtl/data_sync.sv
// Destination-side receiver for a multi-bit bus qualified by a level enable.
// bus_enable is synchronized, its rising edge detected, and on that edge the
// (by then stable) unsynchronized bus is captured into Sync_bus while
// enable_pulse is raised for exactly one CLK cycle.
//
// Output qualifier semantics: enable_pulse acts as a one-cycle valid with no
// ready/back-pressure. In the cycle enable_pulse is high, Sync_bus already
// holds the newly captured word; Sync_bus then holds that word until the next
// pulse. A consumer that must see every word has to sample on every pulse.
module data_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES = DS_NUM_STAGES,
    parameter int BUS_WIDTH  = DS_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] Unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] Sync_bus,
    output logic                 enable_pulse
);

    // Synchronized enable level and its one-cycle rising-edge strobe.
    logic                 w_sync_en;
    logic                 w_pulse;

    // Previous synchronized level, used for edge detection.
    logic                 r_prev_en;
    logic                 r_enable_pulse;
    logic [BUS_WIDTH-1:0] r_sync_bus;

    // Only the qualifier is synchronized; the bus itself is sampled directly
    // because the source holds it stable while bus_enable is high.
    data_sync_bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_async (bus_enable),
        .o_sync  (w_sync_en)
    );

    // Rising edge of the synchronized enable. After reset r_prev_en is 0, so an
    // enable that is already high is treated as a fresh edge.
    assign w_pulse = w_sync_en & ~r_prev_en;

    // Track the last synchronized enable level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prev_en <= 1'b0;
        end else begin
            r_prev_en <= w_sync_en;
        end
    end

    // Register the edge strobe so enable_pulse lines up with the captured data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_enable_pulse <= 1'b0;
        end else begin
            r_enable_pulse <= w_pulse;
        end
    end

    // Capture the bus on the detected edge; hold it otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_bus <= '0;
        end else if (w_pulse) begin
            r_sync_bus <= Unsync_bus;
        end
    end

    assign Sync_bus     = r_sync_bus;
    assign enable_pulse = r_enable_pulse;

endmodule : data_sync

// File: tb/tb_data_sync.sv
// Self-checking bench for data_sync. Two instances share clock, reset and
// bus_enable: one at the default depth/width, one with three stages and a
// 16-bit bus. The reference model records the enable level sampled at every
// edge since reset release and predicts a capture at edge n whenever the level
// seen NUM_STAGES edges earlier is high and the one before it is low.
module tb_data_sync;

    localparam int NS_A = 2;
    localparam int W_A  = 8;
    localparam int NS_B = 3;
    localparam int W_B  = 16;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #50 CLK = ~CLK;

    logic           bus_enable = 1'b0;
    logic [W_A-1:0] bus_a      = '0;
    logic [W_B-1:0] bus_b      = '0;
    logic [W_A-1:0] sync_a;
    logic [W_B-1:0] sync_b;
    logic           pulse_a;
    logic           pulse_b;

    data_sync #(.NUM_STAGES(NS_A), .BUS_WIDTH(W_A)) dut_a (
        .CLK          (CLK),
        .RST          (RST),
        .Unsync_bus   (bus_a),
        .bus_enable   (bus_enable),
        .Sync_bus     (sync_a),
        .enable_pulse (pulse_a)
    );

    data_sync #(.NUM_STAGES(NS_B), .BUS_WIDTH(W_B)) dut_b (
        .CLK          (CLK),
        .RST          (RST),
        .Unsync_bus   (bus_b),
        .bus_enable   (bus_enable),
        .Sync_bus     (sync_b),
        .enable_pulse (pulse_b)
    );

    // ---------------- scoreboard state ----------------
    int             n_tests = 0;
    int             n_fail  = 0;
    int             edge_n  = 0;
    bit             mon_en  = 1'b0;
    bit             en_q[$];
    logic [W_A-1:0] exp_q_a[$];
    int             exp_cyc_a[$];
    logic [W_B-1:0] exp_q_b[$];
    int             exp_cyc_b[$];
    logic [W_A-1:0] hold_a = '0;
    logic [W_B-1:0] hold_b = '0;

    // Edges counted since the last reset release.
    always @(posedge CLK or negedge RST) begin
        if (!RST) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    // Enable level sampled at edge e (edges before release read as 0).
    function automatic bit en_at(input int e);
        if (e < 1 || e > en_q.size()) return 1'b0;
        return en_q[e-1];
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge: drives inputs for the next rising edge, records
    // the model's prediction, then waits one full cycle.
    task automatic step(input bit en, input logic [W_A-1:0] a, input logic [W_B-1:0] b);
        int n;
        bus_enable = en;
        bus_a      = a;
        bus_b      = b;
        en_q.push_back(en);
        n = en_q.size();
        if (en_at(n - NS_A) && !en_at(n - NS_A - 1)) begin
            exp_q_a.push_back(a);
            exp_cyc_a.push_back(n);
        end
        if (en_at(n - NS_B) && !en_at(n - NS_B - 1)) begin
            exp_q_b.push_back(b);
            exp_cyc_b.push_back(n);
        end
        @(negedge CLK);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
    task automatic do_reset();
        #20;
        RST = 1'b0;
        #1;
        check("rst_sync_a",  {24'd0, sync_a}, 32'd0);
        check("rst_pulse_a", {31'd0, pulse_a}, 32'd0);
        check("rst_sync_b",  {16'd0, sync_b}, 32'd0);
        check("rst_pulse_b", {31'd0, pulse_b}, 32'd0);
        en_q.delete();
        exp_q_a.delete();
        exp_cyc_a.delete();
        exp_q_b.delete();
        exp_cyc_b.delete();
        hold_a = '0;
        hold_b = '0;
        mon_en = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // ---------------- monitor ----------------
    task automatic mon_a();
        bit exp_p = 1'b0;
        if (exp_cyc_a.size() > 0 && exp_cyc_a[0] == edge_n) begin
            exp_p  = 1'b1;
            hold_a = exp_q_a.pop_front();
            void'(exp_cyc_a.pop_front());
        end
        check("pulse_a", {31'd0, pulse_a}, {31'd0, exp_p});
        check("sync_a",  {24'd0, sync_a},  {24'd0, hold_a});
    endtask

    task automatic mon_b();
        bit exp_p = 1'b0;
        if (exp_cyc_b.size() > 0 && exp_cyc_b[0] == edge_n) begin
            exp_p  = 1'b1;
            hold_b = exp_q_b.pop_front();
            void'(exp_cyc_b.pop_front());
        end
        check("pulse_b", {31'd0, pulse_b}, {31'd0, exp_p});
        check("sync_b",  {16'd0, sync_b},  {16'd0, hold_b});
    endtask

    always @(negedge CLK) begin
        if (mon_en && RST === 1'b1) begin
            mon_a();
            mon_b();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(negedge CLK);
        do_reset();

        // First transfer: edge k = 1.
        step(1'b1, 8'hCA, 16'hBEEF);
        check("k_sync_a",   {24'd0, sync_a},  32'h00);
        check("k_pulse_a",  {31'd0, pulse_a}, 32'd0);
        step(1'b1, 8'hCA, 16'hBEEF);
        step(1'b1, 8'hCA, 16'hBEEF);
        check("k2_sync_a",  {24'd0, sync_a},  32'hCA);
        check("k2_pulse_a", {31'd0, pulse_a}, 32'd1);
        check("k2_pulse_b", {31'd0, pulse_b}, 32'd0);
        step(1'b1, 8'hCA, 16'hBEEF);
        check("k3_pulse_a", {31'd0, pulse_a}, 32'd0);
        check("k3_sync_a",  {24'd0, sync_a},  32'hCA);
        check("k3_sync_b",  {16'd0, sync_b},  32'hBEEF);
        check("k3_pulse_b", {31'd0, pulse_b}, 32'd1);
        step(1'b1, 8'hCA, 16'hBEEF);
        check("k4_pulse_b", {31'd0, pulse_b}, 32'd0);

        // Long high enable with changing bus: no new capture.
        for (int i = 0; i < 10; i++) step(1'b1, 8'h35, 16'h1234);
        check("hold_sync_a", {24'd0, sync_a}, 32'hCA);
        check("hold_sync_b", {16'd0, sync_b}, 32'hBEEF);

        // Drop two cycles, re-raise with new data.
        step(1'b0, 8'h35, 16'h1234);
        step(1'b0, 8'h35, 16'h1234);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h35, 16'h1234);
        check("re_sync_a", {24'd0, sync_a}, 32'h35);
        check("re_sync_b", {16'd0, sync_b}, 32'h1234);

        // Back-to-back: one-cycle low gap gives two captures.
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 16'h0000);
        step(1'b1, 8'h11, 16'h1111);
        step(1'b0, 8'h22, 16'h2222);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h33, 16'h3333);
        check("b2b_sync_a", {24'd0, sync_a}, 32'h33);

        // Reset with an edge in flight, enable still high after release.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 16'h0000);
        step(1'b1, 8'h77, 16'h7777);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h77, 16'h7777);
        check("post_rst_sync_a", {24'd0, sync_a}, 32'h77);
        check("post_rst_sync_b", {16'd0, sync_b}, 32'h7777);

        // Randomized segments with occasional resets.
        for (int seg = 0; seg < 250; seg++) begin
            bit             en  = 1'($urandom_range(0, 1));
            int             len = int'($urandom_range(1, 6));
            logic [W_A-1:0] a   = W_A'($urandom);
            logic [W_B-1:0] b   = W_B'($urandom);
            for (int i = 0; i < len; i++) step(en, a, b);
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        // Drain: every predicted capture must have been seen.
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 16'h0000);
        check("drain_q_a", exp_q_a.size(), 32'd0);
        check("drain_q_b", exp_q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_sync
